// File: rtl/la_pkg.sv
// Shared logic-analyzer types and constants.
// Used by the protocol trigger units and channel front ends.
package la_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_trig_state_t;

   localparam logic [15:0] UART_MIN_BAUD  = 16'd4;
   localparam int          UART_DATA_BITS = 8;

endpackage

// File: rtl/sync_flop.sv
// N-stage synchronizer for an asynchronous single-bit input; N clocks latency.
// No backpressure; RST_VAL is loaded into every stage so the output is defined in reset.
module sync_flop #(
   parameter int   N       = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [N-1:0] stg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stg <= {N{RST_VAL}};
      end else begin
         stg <= {stg[N-2:0], d};
      end
   end

   assign q = stg[N-1];

endmodule

// File: rtl/uart_prot_trig.sv
// UART 8N1 decoder on CH1 that pulses UARTtrig for one clock on a matching, well-framed byte.
// Pulse lands SYNC_STAGES+2+baud/2+9*baud clocks after the RX fall; no backpressure.
module uart_prot_trig
   import la_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX,
   input  logic [15:0] baud_cnt,
   input  logic [7:0]  match,
   input  logic [7:0]  mask,
   output logic        UARTtrig
);

   localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

   logic             rx_s;
   logic             rx_prev;
   uart_trig_state_t state, state_nxt;
   logic [15:0]      baud_lat, baud_lat_nxt;
   logic [15:0]      cnt, cnt_nxt;
   logic [15:0]      reload;
   logic [2:0]       idx, idx_nxt;
   logic [7:0]       shift, shift_nxt;
   logic             trig_nxt;
   logic             expired;

   sync_flop #(
      .N       (SYNC_STAGES),
      .RST_VAL (1'b1)
   ) u_rx_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (RX),
      .q     (rx_s)
   );

   // A zero baud would otherwise wrap the reload to 16'hFFFF and stall the FSM.
   assign reload  = (baud_lat == 16'd0) ? 16'd0 : baud_lat - 16'd1;
   assign expired = (cnt == 16'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_prev  <= 1'b1;
         state    <= IDLE;
         baud_lat <= 16'd0;
         cnt      <= 16'd0;
         idx      <= 3'd0;
         shift    <= 8'h00;
         UARTtrig <= 1'b0;
      end else begin
         rx_prev  <= rx_s;
         state    <= state_nxt;
         baud_lat <= baud_lat_nxt;
         cnt      <= cnt_nxt;
         idx      <= idx_nxt;
         shift    <= shift_nxt;
         UARTtrig <= trig_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      baud_lat_nxt = baud_lat;
      cnt_nxt      = cnt;
      idx_nxt      = idx;
      shift_nxt    = shift;
      trig_nxt     = 1'b0;
      case (state)
         IDLE: begin
            if (rx_prev && !rx_s) begin
               baud_lat_nxt = baud_cnt;
               cnt_nxt      = baud_cnt >> 1;
               idx_nxt      = 3'd0;
               state_nxt    = START;
            end
         end
         START: begin
            if (!expired) begin
               cnt_nxt = cnt - 16'd1;
            end else if (rx_s) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt   = reload;
               state_nxt = DATA;
            end
         end
         DATA: begin
            if (!expired) begin
               cnt_nxt = cnt - 16'd1;
            end else begin
               shift_nxt = {rx_s, shift[7:1]};
               cnt_nxt   = reload;
               idx_nxt   = idx + 3'd1;
               if (idx == LAST_BIT) begin
                  state_nxt = STOP;
               end
            end
         end
         STOP: begin
            if (!expired) begin
               cnt_nxt = cnt - 16'd1;
            end else begin
               trig_nxt  = rx_s && (((shift ^ match) & ~mask) == 8'h00);
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
